branch_ctrl: RTL
================

# branch_ctrl

Branch resolution unit feeding the program-counter block. It takes decoded branch requests plus the ALU condition flag, resolves taken/not-taken, and drives the fetch block's `Jump`, `BranchAbsOrRel` and `Target` inputs from registered outputs. Absolute and relative targets come from constant lookup tables indexed by the 3-bit instruction immediate. An optional return-address stack supports CALL/RET. The unit sits between the decoder/ALU flags and the fetch block.

## Interface
- `DEPTH`, 4, return-address stack entries (power of two, ≥2)
- `PCW`, 10, program-counter width
- `Clk`  in  1  rising-edge clock
- `Reset`  in  1  synchronous, active-high reset
- `Start`  in  1  program-start hold; same clearing as `Reset` but lower priority
- `ProgCtr`  in  PCW  current PC from the fetch block
- `BrReq`  in  1  current instruction is a branch
- `BrKind`  in  2  0=BEQ_ABS, 1=BNE_REL, 2=CALL, 3=RET
- `BrIdx`  in  3  lookup-table index
- `CondFlag`  in  1  ALU condition flag
- `Jump`  out  1  to fetch block, registered
- `BranchAbsOrRel`  out  1  0=absolute, 1=relative, registered
- `Target`  out  PCW  absolute PC or two's-complement offset, registered
- `Squash`  out  1  instruction fetched this cycle is invalid
- `RasErr`  out  1  sticky stack overflow/underflow flag

## Operation
- FSM states:
  - IDLE: outputs low.
  - ISSUE: `Jump`=1 and `Squash`=1, held exactly one cycle.
- IDLE→ISSUE on a taken request; ISSUE→IDLE unconditionally.
- `BrReq` sampled during ISSUE is ignored, because that instruction is squashed.
- Take rules:
  - BEQ_ABS is taken if `CondFlag`=1; `Target`=abs_lut[BrIdx], `BranchAbsOrRel`=0.
  - BNE_REL is taken if `CondFlag`=0; `Target`=sign-extended rel_lut[BrIdx], `BranchAbsOrRel`=1.
  - CALL is unconditional; `Target`=abs_lut[BrIdx], abs; pushes (`ProgCtr`+1) mod 2^PCW.
  - RET is unconditional if the stack is non-empty; `Target`=popped value, abs.
- Relative offsets are relative to the PC seen in ISSUE, which is the branch PC+1. The fetch block computes `ProgCtr`+`Target` modulo 2^PCW, so the target wraps.
- Not-taken requests: stay in IDLE, no `Jump`, no `Squash`.
- Push when the stack is full:
  - the push is dropped and `RasErr` is set;
  - the jump is still issued;
  - existing entries are unchanged.
- Pop when the stack is empty:
  - no jump;
  - `RasErr` is set.
- `RasErr` clears only on `Reset`/`Start`.
- Priority: `Reset` > `Start` > request.
- `Start` clears the FSM, all outputs and the stack pointer, and suppresses issue while high.
- Reset values: `Jump`=0, `BranchAbsOrRel`=0, `Target`=0, `Squash`=0, `RasErr`=0, stack empty, FSM in IDLE.

## Timing
- Request in cycle N; `Jump`/`Target`/`Squash` are valid throughout cycle N+1.
- The fetch block loads the new PC at the N+1→N+2 edge.
- Branch penalty: one squashed slot (the N+1 fetch) on taken branches; zero on not-taken.
- Stack push/pop commit at the N→N+1 edge.
- `Reset` asserted during ISSUE: all outputs read 0 in the cycle after that edge, and no PC change occurs.
- Back-to-back taken branches are possible at cycle N and at N+2 at the earliest.

## Configuration
- `BRANCH_RAS_EN` defined:
  - the stack of `DEPTH` entries is present;
  - CALL/RET behave as above.
- `BRANCH_RAS_EN` undefined:
  - no stack storage;
  - CALL acts as an unconditional absolute jump with no push;
  - RET is treated as not-taken;
  - `RasErr` is tied to 0.

## Structure
- Package `branch_pkg` holds:
  - `br_kind_t` enum;
  - `PCW` default;
  - abs_lut = {0, 40, 80, 120, 200, 300, 400, 1000};
  - rel_lut = {+1, +2, +4, +8, −1, −2, −4, −8} (signed 8-bit);
  - FSM state enum.
- Sub-module `ret_stack` (inputs: push, pop, data; outputs: full, empty, top) is instantiated only under `BRANCH_RAS_EN`.

## Test plan
- BEQ_ABS, BrIdx=2, CondFlag=1 at PC=10 → next cycle `Jump`=1, `BranchAbsOrRel`=0, `Target`=80, `Squash`=1 for one cycle; fetch PC becomes 80.
- BNE_REL, BrIdx=4, CondFlag=0 at PC=50 → `Target`=10'h3FF, rel; PC returns to 50. Same request with CondFlag=1 → no `Jump`, no `Squash`, PC reaches 52.
- CALL, BrIdx=1 at PC=1023 → `Target`=40, push 0 (wrap). A later RET → `Target`=0, abs.
- Five CALLs with DEPTH=4:
  - the fifth still jumps and sets `RasErr`=1;
  - four RETs return in LIFO order;
  - the fifth RET gives no `Jump`, and `RasErr` stays 1.
- `BrReq` asserted during ISSUE → ignored.
- `Reset` during ISSUE → outputs 0 next cycle and the stack is empty.
- `Start` held with a taken request → no `Jump`.
- Built without `BRANCH_RAS_EN`: CALL idx3 → `Target`=120; RET → no `Jump`, `RasErr`=0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constant tables for the branch resolution unit.
// Configuration macro used by the unit: BRANCH_RAS_EN (return-address stack).
package branch_pkg;

    localparam int PCW_DEFAULT = 10;

    typedef enum logic [1:0] {
        BEQ_ABS = 2'd0,
        BNE_REL = 2'd1,
        CALL    = 2'd2,
        RET     = 2'd3
    } br_kind_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } br_state_t;

    // Absolute branch/call targets, indexed by the 3-bit immediate
    function automatic int abs_lut(input logic [2:0] idx);
        case (idx)
            3'd0:    abs_lut = 0;
            3'd1:    abs_lut = 40;
            3'd2:    abs_lut = 80;
            3'd3:    abs_lut = 120;
            3'd4:    abs_lut = 200;
            3'd5:    abs_lut = 300;
            3'd6:    abs_lut = 400;
            default: abs_lut = 1000;
        endcase
    endfunction

    // Signed relative offsets, applied to the PC seen in ISSUE (branch PC + 1)
    function automatic logic signed [7:0] rel_lut(input logic [2:0] idx);
        case (idx)
            3'd0:    rel_lut = 8'sd1;
            3'd1:    rel_lut = 8'sd2;
            3'd2:    rel_lut = 8'sd4;
            3'd3:    rel_lut = 8'sd8;
            3'd4:    rel_lut = -8'sd1;
            3'd5:    rel_lut = -8'sd2;
            3'd6:    rel_lut = -8'sd4;
            default: rel_lut = -8'sd8;
        endcase
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address stack (LIFO). Only instantiated when BRANCH_RAS_EN is defined.
// A push while full or a pop while empty is ignored; the caller flags the error.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int PCW   = 10
) (
    input  logic           Clk,
    input  logic           Clear,
    input  logic           push,
    input  logic           pop,
    input  logic [PCW-1:0] data,
    output logic           full,
    output logic           empty,
    output logic [PCW-1:0] top
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW:0]    cnt;
    logic [AW:0]    cnt_m1;
    logic [PCW-1:0] mem [DEPTH];

    assign full   = (cnt == FULL_CNT);
    assign empty  = (cnt == '0);
    assign cnt_m1 = cnt - ONE;
    assign top    = mem[cnt_m1[AW-1:0]];

    // Occupancy count; cleared by reset or program start
    always_ff @(posedge Clk) begin
        if (Clear)
            cnt <= '0;
        else if (push && !full)
            cnt <= cnt + ONE;
        else if (pop && !empty)
            cnt <= cnt_m1;
    end

    // Entry storage; entries above the count are don't-care so no reset
    always_ff @(posedge Clk) begin
        if (!Clear && push && !full)
            mem[cnt[AW-1:0]] <= data;
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution unit: resolves taken/not-taken from decoded requests and
// the ALU flag, and drives registered Jump/BranchAbsOrRel/Target to fetch.
// Configuration macro: BRANCH_RAS_EN adds the CALL/RET return-address stack.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PCW   = PCW_DEFAULT
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Start,
    input  logic [PCW-1:0] ProgCtr,
    input  logic           BrReq,
    input  logic [1:0]     BrKind,
    input  logic [2:0]     BrIdx,
    input  logic           CondFlag,
    output logic           Jump,
    output logic           BranchAbsOrRel,
    output logic [PCW-1:0] Target,
    output logic           Squash,
    output logic           RasErr
);

    br_state_t             state, state_nxt;
    br_kind_t              kind;
    logic                  take_p0;
    logic                  rel_p0;
    logic [PCW-1:0]        tgt_p0;
    logic signed [PCW-1:0] rel_ext;

    assign kind    = br_kind_t'(BrKind);
    assign rel_ext = PCW'(rel_lut(BrIdx));

`ifdef BRANCH_RAS_EN
    logic           push, pop, err_set;
    logic           ras_full, ras_empty;
    logic [PCW-1:0] ras_top;
    logic [PCW-1:0] ret_addr;

    assign ret_addr = ProgCtr + PCW'(1);

    ret_stack #(.DEPTH(DEPTH), .PCW(PCW)) u_ras (
        .Clk   (Clk),
        .Clear (Reset || Start),
        .push  (push),
        .pop   (pop),
        .data  (ret_addr),
        .full  (ras_full),
        .empty (ras_empty),
        .top   (ras_top)
    );
`else
    logic unused_ok;
    assign unused_ok = ^{ProgCtr, DEPTH[0]};
`endif

    // Resolve the request and compute next FSM state; requests in ISSUE are squashed
    always_comb begin
        take_p0   = 1'b0;
        rel_p0    = 1'b0;
        tgt_p0    = '0;
        state_nxt = IDLE;
`ifdef BRANCH_RAS_EN
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;
`endif
        if (state == IDLE && BrReq && !Start) begin
            case (kind)
                BEQ_ABS: begin
                    if (CondFlag) begin
                        take_p0 = 1'b1;
                        tgt_p0  = PCW'(abs_lut(BrIdx));
                    end
                end
                BNE_REL: begin
                    if (!CondFlag) begin
                        take_p0 = 1'b1;
                        rel_p0  = 1'b1;
                        tgt_p0  = rel_ext;
                    end
                end
                CALL: begin
                    take_p0 = 1'b1;
                    tgt_p0  = PCW'(abs_lut(BrIdx));
`ifdef BRANCH_RAS_EN
                    if (ras_full)
                        err_set = 1'b1;
                    else
                        push = 1'b1;
`endif
                end
                RET: begin
`ifdef BRANCH_RAS_EN
                    if (ras_empty) begin
                        err_set = 1'b1;
                    end else begin
                        take_p0 = 1'b1;
                        pop     = 1'b1;
                        tgt_p0  = ras_top;
                    end
`endif
                end
                default: ;
            endcase
        end
        case (state)
            IDLE:    state_nxt = take_p0 ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and fetch-facing output registers; Reset and Start both clear
    always_ff @(posedge Clk) begin
        if (Reset || Start) begin
            state          <= IDLE;
            Jump           <= 1'b0;
            Squash         <= 1'b0;
            BranchAbsOrRel <= 1'b0;
            Target         <= '0;
        end else begin
            state          <= state_nxt;
            Jump           <= take_p0;
            Squash         <= take_p0;
            BranchAbsOrRel <= rel_p0;
            Target         <= tgt_p0;
        end
    end

`ifdef BRANCH_RAS_EN
    // Sticky stack overflow/underflow flag
    always_ff @(posedge Clk) begin
        if (Reset || Start)
            RasErr <= 1'b0;
        else if (err_set)
            RasErr <= 1'b1;
    end
`else
    assign RasErr = 1'b0;
`endif

endmodule
